// File: rtl/image_store.sv
// image_store: 64x64 (2^AW x DW) pixel store on the read side of the
// interpolation engine. The host streams the image in raster order through
// W_VALID/W_DATA; after 2^AW accepted writes READY rises and active-low
// reads (REN/ADDR) return R_DATA one cycle later.
//
// Ports:
//   clk       clock
//   RST       asynchronous active-high reset
//   CLEAR     synchronous restart of loading (memory contents kept)
//   W_VALID   write strobe, W_DATA sampled when high
//   W_DATA    pixel data, raster order
//   REN       read enable, active-low
//   ADDR      read address, h + (v << LINE_SHIFT)
//   R_DATA    registered read data
//   READY     image fully loaded
//   LOAD_CNT  pixels accepted since last RST/CLEAR (0..2^AW)
//   ERR       sticky protocol-error flag
module image_store #(
    parameter int unsigned AW         = 12,
    parameter int unsigned DW         = 8,
    parameter int unsigned LINE_SHIFT = 6
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          CLEAR,
    input  logic          W_VALID,
    input  logic [DW-1:0] W_DATA,
    input  logic          REN,
    input  logic [AW-1:0] ADDR,
    output logic [DW-1:0] R_DATA,
    output logic          READY,
    output logic [AW:0]   LOAD_CNT,
    output logic          ERR
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned VW    = AW - LINE_SHIFT;

    typedef enum logic {
        S_LOAD  = 1'b0,
        S_READY = 1'b1
    } state_t;

    logic [DW-1:0]         mem [DEPTH];
    state_t                state;
    logic [AW-1:0]         wptr;

    logic [LINE_SHIFT-1:0] h_c;
    logic [VW-1:0]         v_c;
    logic [AW-1:0]         rd_addr_c;
    logic                  we_c;
    logic                  last_c;

    // Split the address into column/row and rebuild the linear index.
    assign h_c       = ADDR[LINE_SHIFT-1:0];
    assign v_c       = ADDR[AW-1:LINE_SHIFT];
    assign rd_addr_c = AW'(h_c) + (AW'(v_c) << LINE_SHIFT);

    // Writes are only accepted while loading; CLEAR drops a coincident write.
    assign we_c   = (state == S_LOAD) && W_VALID && !CLEAR;
    assign last_c = (wptr == AW'(DEPTH - 1));

    assign READY = (state == S_READY);

    // Pixel array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_c) begin
            mem[wptr] <= W_DATA;
        end
    end

    // Load/serve FSM with registered outputs.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state    <= S_LOAD;
            wptr     <= '0;
            LOAD_CNT <= '0;
            ERR      <= 1'b0;
            R_DATA   <= '0;
        end else begin
            // Reads outside S_READY return zero; REN high holds the last value.
            if (!REN) begin
                R_DATA <= (state == S_READY) ? mem[rd_addr_c] : '0;
            end

            if (CLEAR) begin
                state    <= S_LOAD;
                wptr     <= '0;
                LOAD_CNT <= '0;
                ERR      <= 1'b0;
            end else begin
                case (state)
                    S_LOAD: begin
                        if (W_VALID) begin
                            wptr     <= wptr + AW'(1);
                            LOAD_CNT <= LOAD_CNT + (AW+1)'(1);
                            if (last_c) begin
                                state <= S_READY;
                            end
                        end
                        if (!REN) begin
                            ERR <= 1'b1;
                        end
                    end
                    S_READY: begin
                        if (W_VALID) begin
                            ERR <= 1'b1;
                        end
                    end
                    default: state <= S_LOAD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_image_store.sv
// tb_image_store: directed bench for image_store. A vector table covers
// reads, late writes, early reads and CLEAR interactions; hand-written
// sequences cover full/gapped loads, CLEAR during load and async RST.
module tb_image_store;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        w_valid;
    logic [7:0]  w_data;
    logic        ren;
    logic [11:0] addr;
    logic [7:0]  r_data;
    logic        ready;
    logic [12:0] load_cnt;
    logic        err;

    int n_vec;
    int n_err;

    typedef struct {
        logic        clear;
        logic        w_valid;
        logic [7:0]  w_data;
        logic        ren;
        logic [11:0] addr;
        logic [7:0]  exp_rdata;
        logic        exp_ready;
        logic [12:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t vecs [15];

    image_store dut (
        .clk      (clk),
        .RST      (rst),
        .CLEAR    (clear),
        .W_VALID  (w_valid),
        .W_DATA   (w_data),
        .REN      (ren),
        .ADDR     (addr),
        .R_DATA   (r_data),
        .READY    (ready),
        .LOAD_CNT (load_cnt),
        .ERR      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] rd, input logic rdy,
                           input logic [12:0] cnt, input logic e);
        chk({name, ".r_data"},   32'(r_data),   32'(rd));
        chk({name, ".ready"},    32'(ready),    32'(rdy));
        chk({name, ".load_cnt"}, 32'(load_cnt), 32'(cnt));
        chk({name, ".err"},      32'(err),      32'(e));
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes pixel value i[7:0] for i in [from, to), optionally with an idle cycle after each.
    task automatic load_range(input int from, input int to, input bit gap);
        for (int i = from; i < to; i++) begin
            w_valid = 1'b1;
            w_data  = 8'(i);
            tick();
            w_valid = 1'b0;
            if (gap) tick();
        end
    endtask

    task automatic write_one(input logic [7:0] d);
        w_valid = 1'b1;
        w_data  = d;
        tick();
        w_valid = 1'b0;
    endtask

    task automatic read_one(input logic [11:0] a);
        ren  = 1'b0;
        addr = a;
        tick();
        ren  = 1'b1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        clear   = 1'b0;
        w_valid = 1'b0;
        w_data  = '0;
        ren     = 1'b1;
        addr    = '0;

        //              clr   wv    wdata  ren   addr     rdata  rdy   cnt        err
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h041, 8'h41, 1'b1, 13'd4096, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h000, 8'h00, 1'b1, 13'd4096, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h03F, 8'h3F, 1'b1, 13'd4096, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 12'hFC0, 8'hC0, 1'b1, 13'd4096, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 12'hFFF, 8'hFF, 1'b1, 13'd4096, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 12'h123, 8'hFF, 1'b1, 13'd4096, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h55, 1'b1, 12'h000, 8'hFF, 1'b1, 13'd4096, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h000, 8'h00, 1'b1, 13'd4096, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h0AB, 8'hAB, 1'b1, 13'd4096, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 12'h000, 8'hAB, 1'b0, 13'd0,    1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h005, 8'h00, 1'b0, 13'd0,    1'b1};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 12'h000, 8'h00, 1'b0, 13'd0,    1'b0};
        vecs[12] = '{1'b0, 1'b1, 8'h77, 1'b1, 12'h000, 8'h00, 1'b0, 13'd1,    1'b0};
        vecs[13] = '{1'b0, 1'b1, 8'h78, 1'b0, 12'h000, 8'h00, 1'b0, 13'd2,    1'b1};
        vecs[14] = '{1'b1, 1'b1, 8'h99, 1'b0, 12'h000, 8'h00, 1'b0, 13'd0,    1'b0};

        // Reset values while RST is held.
        #3;
        chk_all("reset", 8'h00, 1'b0, 13'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Ramp load on consecutive cycles.
        load_range(0, 4095, 1'b0);
        chk_all("ramp_pre_last", 8'h00, 1'b0, 13'd4095, 1'b0);
        load_range(4095, 4096, 1'b0);
        chk_all("ramp_done", 8'h00, 1'b1, 13'd4096, 1'b0);

        // Vector table: reads, late write, CLEAR and early-read interactions.
        for (int v = 0; v < 15; v++) begin
            clear   = vecs[v].clear;
            w_valid = vecs[v].w_valid;
            w_data  = vecs[v].w_data;
            ren     = vecs[v].ren;
            addr    = vecs[v].addr;
            tick();
            chk_all($sformatf("vec%0d", v), vecs[v].exp_rdata, vecs[v].exp_ready,
                    vecs[v].exp_cnt, vecs[v].exp_err);
        end
        clear   = 1'b0;
        w_valid = 1'b0;
        ren     = 1'b1;

        // Early read after 10 writes; ERR sticks through the rest of the load.
        load_range(0, 10, 1'b0);
        read_one(12'h005);
        chk_all("early_read", 8'h00, 1'b0, 13'd10, 1'b1);
        load_range(10, 4096, 1'b0);
        chk_all("early_load_done", 8'h00, 1'b1, 13'd4096, 1'b1);
        pulse_clear();
        chk_all("early_clear", 8'h00, 1'b0, 13'd0, 1'b0);

        // Gapped load: count only advances on strobes.
        load_range(0, 2001, 1'b1);
        chk_all("gap_mid", 8'h00, 1'b0, 13'd2001, 1'b0);
        load_range(2001, 4095, 1'b1);
        chk_all("gap_pre_last", 8'h00, 1'b0, 13'd4095, 1'b0);
        load_range(4095, 4096, 1'b0);
        chk_all("gap_done", 8'h00, 1'b1, 13'd4096, 1'b0);
        write_one(8'h55);
        chk_all("late_write", 8'h00, 1'b1, 13'd4096, 1'b1);
        read_one(12'h000);
        chk("late_mem0", 32'(r_data), 32'h00);
        read_one(12'hABC);
        chk("late_rd_abc", 32'(r_data), 32'hBC);

        // CLEAR coincident with a write at LOAD_CNT=100 drops that write.
        pulse_clear();
        load_range(0, 100, 1'b0);
        chk("clrw_cnt100", 32'(load_cnt), 32'd100);
        clear   = 1'b1;
        w_valid = 1'b1;
        w_data  = 8'h11;
        tick();
        clear   = 1'b0;
        w_valid = 1'b0;
        chk_all("clrw_after", 8'hBC, 1'b0, 13'd0, 1'b0);
        write_one(8'hAA);
        chk("clrw_cnt1", 32'(load_cnt), 32'd1);
        load_range(1, 4096, 1'b0);
        chk("clrw_ready", 32'(ready), 32'd1);
        read_one(12'h000);
        chk("clrw_mem0", 32'(r_data), 32'hAA);
        read_one(12'h001);
        chk("clrw_mem1", 32'(r_data), 32'h01);

        // Async RST between edges mid-load.
        pulse_clear();
        load_range(0, 2000, 1'b0);
        chk_all("rst_pre", 8'h01, 1'b0, 13'd2000, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("rst_async", 8'h00, 1'b0, 13'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        load_range(0, 4096, 1'b0);
        chk_all("rst_reload", 8'h00, 1'b1, 13'd4096, 1'b0);
        read_one(12'hFFF);
        chk("rst_rd_fff", 32'(r_data), 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/image_store.md
# image_store

Synchronous 64x64 8-bit image store that sits on the memory side of the interpolation engine's read port. A host streams the source image in raster order through a write port. Once all 4096 pixels are loaded, the block raises READY and serves active-low read requests (REN/ADDR) with one-cycle latency. The host must not pulse START on the interpolation engine until READY is high.

## Interface
Parameters:
- AW, 12: address width; depth is 2^AW = 4096 pixels.
- DW, 8: pixel width.
- LINE_SHIFT, 6: log2 of the row length; address = h + (v << LINE_SHIFT).

Ports:
- clk  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- CLEAR  in  1  synchronous restart of loading. Returns to LOAD and resets the write pointer and ERR; memory contents are kept.
- W_VALID  in  1  write strobe; W_DATA is sampled on the rising edge when high.
- W_DATA  in  DW  pixel data, raster order (h fastest).
- REN  in  1  read enable, active-low.
- ADDR  in  AW  read address.
- R_DATA  out  DW  read data, registered.
- READY  out  1  image fully loaded; reads are valid.
- LOAD_CNT  out  AW+1  number of pixels written since the last RST/CLEAR (0..4096).
- ERR  out  1  sticky protocol-error flag.

## Operation
- Storage: 2^AW x DW register array. It is not reset, and contents are undefined until written.
- FSM states: S_LOAD (the reset state) and S_READY.
  - S_LOAD: each cycle with W_VALID=1, write W_DATA to mem[wptr], then increment wptr and LOAD_CNT. On the write with wptr = 4095, go to S_READY on the same edge.
  - S_READY: W_VALID=1 is ignored (memory unchanged) and sets ERR.
  - CLEAR=1 in either state: next state S_LOAD, wptr=0, LOAD_CNT=0, ERR=0.
  - CLEAR has priority over a simultaneous W_VALID (that write is dropped) and over a simultaneous read error.
- Read in S_READY: REN=0 sampled at an edge gives R_DATA = mem[ADDR] after that edge.
- Read in S_LOAD: REN=0 gives R_DATA = 0 and sets ERR.
- REN=1: R_DATA holds its previous value.
- Read/write collision: a write and a read to the same address in the same cycle cannot happen, because writes and legal reads are in disjoint states.
- READY = (state == S_READY), driven from a registered state.
- Address arithmetic is unsigned, with no bounds check. Any 12-bit ADDR is legal and maps directly.
- Reset values: R_DATA=0, READY=0, LOAD_CNT=0, ERR=0, state=S_LOAD, wptr=0.
- RST mid-load: all of the above are reset immediately. Partially written contents remain but are considered invalid, and a full reload of 4096 pixels is required.

## Timing
- Write latency: W_DATA sampled at edge k is readable by a request sampled at edge k+1 or later, if READY is high by then.
- READY rises on the edge that samples the 4096th W_VALID. It is high in the following cycle.
- Read latency is exactly 1 cycle: REN/ADDR sampled at edge k, R_DATA valid from edge k until edge k+1.
  - This matches the interpolation engine, which consumes R_DATA in the cycle after it issues ADDR.
- Back-to-back reads are allowed every cycle (throughput 1 pixel/cycle).
- W_VALID gaps are allowed; LOAD_CNT only advances on accepted writes.
- ERR updates on the edge after the offending event and stays high until RST or CLEAR.
- No combinational path from inputs to outputs.

## Test plan
- Load ramp: after reset, write mem[i] = i[7:0] for i = 0..4095 on consecutive cycles.
  - READY=0 and LOAD_CNT=4095 before the last write; READY=1 and LOAD_CNT=4096 one cycle after.
  - Then read ADDR=0x041 (h=1, v=1): R_DATA=0x41 one cycle after the REN=0 edge.
- Back-to-back reads: with the ramp loaded, issue REN=0 with ADDR 0x000, 0x03F, 0xFC0, 0xFFF on consecutive cycles.
  - R_DATA = 0x00, 0x3F, 0xC0, 0xFF on the consecutive following cycles.
  - REN=1 afterwards: R_DATA stays 0xFF.
- Early read: after reset and 10 writes, issue REN=0 with ADDR=5.
  - R_DATA=0, ERR=1 next cycle. ERR stays 1 through the remaining load.
  - CLEAR clears ERR and sets LOAD_CNT=0, READY=0.
- Gapped load plus late write: load with W_VALID toggling every other cycle.
  - LOAD_CNT counts only the strobes; READY rises after exactly 4096 strobes.
  - An extra write while READY sets ERR and leaves mem[0] unchanged (verified by a read).
- Simultaneous CLEAR and W_VALID at LOAD_CNT=100: LOAD_CNT=0 next cycle and the write is dropped.
  - Writing 0xAA next goes to address 0; after the full reload, a read of 0 returns 0xAA.
- Async RST mid-load (LOAD_CNT=2000), asserted between clock edges: READY, LOAD_CNT, ERR and R_DATA go to 0 immediately, without waiting for a clock edge.
  - A subsequent full reload reaches READY=1 normally.
